// File: rtl/matrix_tile_sched.sv
// Job-level tile scheduler: walks an output matrix in tiles (column tiles inner loop)
// and presents one MAC-array command per tile, advancing only on controller accept.
module matrix_tile_sched #(
  parameter int FEAT_ADDR_W   = 15,
  parameter int WEIGHT_ADDR_W = 17,
  parameter int OUT_ADDR_W    = 15,
  parameter int N_W           = 12,
  parameter int TILE_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [FEAT_ADDR_W-1:0]   job_a_base,
  input  logic [WEIGHT_ADDR_W-1:0] job_b_base,
  input  logic [OUT_ADDR_W-1:0]    job_c_base,
  input  logic [FEAT_ADDR_W-1:0]   job_a_tile_stride,
  input  logic [WEIGHT_ADDR_W-1:0] job_b_tile_stride,
  input  logic [OUT_ADDR_W-1:0]    job_c_row_stride,
  input  logic [OUT_ADDR_W-1:0]    job_c_col_stride,
  input  logic [14:0]              job_a_line,
  input  logic [16:0]              job_b_line,
  input  logic [14:0]              job_c_line,
  input  logic [N_W-1:0]           job_k,
  input  logic [TILE_W-1:0]        job_tiles_m,
  input  logic [TILE_W-1:0]        job_tiles_n,
  output logic                     ctrl_valid,
  input  logic                     ctrl_accept,
  output logic [FEAT_ADDR_W-1:0]   ctrl_feat_addr,
  output logic [WEIGHT_ADDR_W-1:0] ctrl_weight_addr,
  output logic [OUT_ADDR_W-1:0]    ctrl_out_addr,
  output logic [14:0]              ctrl_a_line,
  output logic [16:0]              ctrl_b_line,
  output logic [14:0]              ctrl_c_line,
  output logic [N_W-1:0]           ctrl_matrix_n,
  output logic                     done,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_e;

  state_e                   state_q, state_d;
  logic                     ctrl_valid_q, ctrl_valid_d;
  logic                     done_q, done_d;
  logic [TILE_W-1:0]        i_q, i_d, j_q, j_d;
  logic [TILE_W-1:0]        tiles_m_q, tiles_m_d, tiles_n_q, tiles_n_d;
  logic [FEAT_ADDR_W-1:0]   a_base_q, a_base_d, a_stride_q, a_stride_d;
  logic [WEIGHT_ADDR_W-1:0] b_stride_q, b_stride_d;
  logic [OUT_ADDR_W-1:0]    c_row_q, c_row_d, c_col_q, c_col_d;
  logic [OUT_ADDR_W-1:0]    row_base_q, row_base_d;
  logic [FEAT_ADDR_W-1:0]   feat_q, feat_d;
  logic [WEIGHT_ADDR_W-1:0] weight_q, weight_d;
  logic [OUT_ADDR_W-1:0]    out_q, out_d;
  logic [14:0]              a_line_q, a_line_d, c_line_q, c_line_d;
  logic [16:0]              b_line_q, b_line_d;
  logic [N_W-1:0]           k_q, k_d;

  logic take_job, tile_acc, last_i, last_j, zero_job;

  assign take_job = (state_q == IDLE) && job_valid;
  assign tile_acc = (state_q == ISSUE) && ctrl_accept;
  assign last_i   = (i_q == tiles_m_q - TILE_W'(1));
  assign last_j   = (j_q == tiles_n_q - TILE_W'(1));
  assign zero_job = (job_tiles_m == '0) || (job_tiles_n == '0) || (job_k == '0);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (job_valid) state_d = zero_job ? FLUSH : ISSUE;
      ISSUE:   if (ctrl_accept && last_i && last_j) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output decode; ctrl_valid and done are registered from the next state
  always_comb begin
    job_ready    = (state_q == IDLE) && !rst;
    busy         = (state_q != IDLE);
    ctrl_valid_d = (state_d == ISSUE);
    done_d       = (state_d == FLUSH);
  end

  // tile walk: every address step is one adder, wrapping at the port width
  always_comb begin
    i_d        = i_q;
    j_d        = j_q;
    tiles_m_d  = tiles_m_q;
    tiles_n_d  = tiles_n_q;
    a_base_d   = a_base_q;
    a_stride_d = a_stride_q;
    b_stride_d = b_stride_q;
    c_row_d    = c_row_q;
    c_col_d    = c_col_q;
    row_base_d = row_base_q;
    feat_d     = feat_q;
    weight_d   = weight_q;
    out_d      = out_q;
    a_line_d   = a_line_q;
    b_line_d   = b_line_q;
    c_line_d   = c_line_q;
    k_d        = k_q;
    if (take_job) begin
      i_d        = '0;
      j_d        = '0;
      tiles_m_d  = job_tiles_m;
      tiles_n_d  = job_tiles_n;
      a_base_d   = job_a_base;
      a_stride_d = job_a_tile_stride;
      b_stride_d = job_b_tile_stride;
      c_row_d    = job_c_row_stride;
      c_col_d    = job_c_col_stride;
      row_base_d = job_c_base;
      feat_d     = job_a_base;
      weight_d   = job_b_base;
      out_d      = job_c_base;
      a_line_d   = job_a_line;
      b_line_d   = job_b_line;
      c_line_d   = job_c_line;
      k_d        = job_k;
    end else if (tile_acc && !(last_i && last_j)) begin
      if (last_j) begin
        j_d        = '0;
        i_d        = i_q + TILE_W'(1);
        feat_d     = a_base_q;
        weight_d   = weight_q + b_stride_q;
        row_base_d = row_base_q + c_row_q;
        out_d      = row_base_q + c_row_q;
      end else begin
        j_d    = j_q + TILE_W'(1);
        feat_d = feat_q + a_stride_q;
        out_d  = out_q + c_col_q;
      end
    end
  end

  // command outputs carry a reset value; descriptor shadows do not need one
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_valid_q <= 1'b0;
      done_q       <= 1'b0;
      feat_q       <= '0;
      weight_q     <= '0;
      out_q        <= '0;
      a_line_q     <= '0;
      b_line_q     <= '0;
      c_line_q     <= '0;
      k_q          <= '0;
    end else begin
      ctrl_valid_q <= ctrl_valid_d;
      done_q       <= done_d;
      feat_q       <= feat_d;
      weight_q     <= weight_d;
      out_q        <= out_d;
      a_line_q     <= a_line_d;
      b_line_q     <= b_line_d;
      c_line_q     <= c_line_d;
      k_q          <= k_d;
    end
  end

  always_ff @(posedge clk) begin
    i_q        <= i_d;
    j_q        <= j_d;
    tiles_m_q  <= tiles_m_d;
    tiles_n_q  <= tiles_n_d;
    a_base_q   <= a_base_d;
    a_stride_q <= a_stride_d;
    b_stride_q <= b_stride_d;
    c_row_q    <= c_row_d;
    c_col_q    <= c_col_d;
    row_base_q <= row_base_d;
  end

  assign ctrl_valid       = ctrl_valid_q;
  assign done             = done_q;
  assign ctrl_feat_addr   = feat_q;
  assign ctrl_weight_addr = weight_q;
  assign ctrl_out_addr    = out_q;
  assign ctrl_a_line      = a_line_q;
  assign ctrl_b_line      = b_line_q;
  assign ctrl_c_line      = c_line_q;
  assign ctrl_matrix_n    = k_q;

endmodule
